// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter + FIFO feeding a transmit-only UART, one write per character.
// Optional `UART_ARB_CRLF_EN: expand each LF (8'h0A) into CR LF on the wire.
module uart_tx_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                uart_busy,
  output logic                uart_wr,
  output logic [7:0]          uart_data,
  output logic [AW:0]         fifo_level
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand_idx;
  logic            grant_found;
  logic            push;
  logic            pop;
  logic [7:0]      push_data;
  logic [7:0]      head;
  logic [7:0]      mem [DEPTH];
  logic [AW:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW:0]     rd_ptr_reg, rd_ptr_next;
  logic            full_reg, empty_reg;
  logic            wr_reg, wr_next;
  logic [7:0]      data_reg, data_next;
`ifdef UART_ARB_CRLF_EN
  logic            cr_done_reg, cr_done_next;
`endif

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = PW'((int'(rr_ptr_reg) + k) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign push      = grant_found && !full_reg;
  assign push_data = req_data[{grant_idx, 3'b000} +: 8];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = push && (grant_idx == PW'(gi));
    end
  endgenerate

  assign wr_ptr_next = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
  assign rd_ptr_next = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
  assign head        = mem[rd_ptr_reg[AW-1:0]];
  assign fifo_level  = wr_ptr_reg - rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Flags are registered from the next pointers, so a same-cycle pop never frees a slot for a push.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      rr_ptr_reg <= PW'(NREQ - 1);
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                    (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      empty_reg  <= (wr_ptr_next == rd_ptr_next);
      if (push) begin
        rr_ptr_reg <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      wr_reg      <= 1'b0;
      data_reg    <= 8'h00;
`ifdef UART_ARB_CRLF_EN
      cr_done_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      wr_reg      <= wr_next;
      data_reg    <= data_next;
`ifdef UART_ARB_CRLF_EN
      cr_done_reg <= cr_done_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    wr_next    = 1'b0;
    data_next  = data_reg;
    pop        = 1'b0;
`ifdef UART_ARB_CRLF_EN
    cr_done_next = cr_done_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!empty_reg && !uart_busy) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        wr_next    = 1'b1;
        state_next = SETTLE;
`ifdef UART_ARB_CRLF_EN
        // LF at the head goes out as CR first; the LF stays queued for the next round.
        if (head == 8'h0A && !cr_done_reg) begin
          data_next    = 8'h0D;
          cr_done_next = 1'b1;
        end else begin
          data_next    = head;
          pop          = 1'b1;
          cr_done_next = 1'b0;
        end
`else
        data_next = head;
        pop       = 1'b1;
`endif
      end
      // The UART needs one cycle after the strobe before busy is trustworthy.
      SETTLE: state_next = WAIT;
      WAIT: begin
        if (!uart_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign uart_wr   = wr_reg;
  assign uart_data = data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a simple UART model raises busy after each write.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              force_busy = 1'b0;
  logic              model_busy = 1'b0;
  logic              uart_busy;
  logic              uart_wr;
  logic [7:0]        uart_data;
  logic [AW:0]       fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wide_cnt = 0;
  int spacing_err = 0;
  logic [7:0] wr_q[$];
  int         wr_cyc[$];

  assign uart_busy = force_busy | model_busy;

  uart_tx_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_busy(uart_busy), .uart_wr(uart_wr),
    .uart_data(uart_data), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // UART model: records each strobe, then reports busy for three cycles.
  initial begin : uart_model
    int  busy_cnt;
    int  last;
    logic prev;
    busy_cnt = 0;
    last = -100;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (uart_wr === 1'b1) begin
        if (prev) wide_cnt++;
        if (cyc - last < 3) spacing_err++;
        wr_q.push_back(uart_data);
        wr_cyc.push_back(cyc);
        last = cyc;
        busy_cnt = 3;
        $display("[%0t] uart write 0x%02h (cycle %0d)", $time, uart_data, cyc);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      prev = (uart_wr === 1'b1);
      model_busy = (busy_cnt > 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    req_data   = '0;
    force_busy = 1'b0;
    step();
    nreset = 1'b0;
    step();
    step();
    nreset = 1'b1;
    step();
  endtask

  task automatic push_byte(input int r, input logic [7:0] d);
    req_data[8*r +: 8] = d;
    req_valid = '0;
    req_valid[r] = 1'b1;
    step();
    req_valid = '0;
  endtask

  task automatic test_reset();
    req_valid = '0;
    force_busy = 1'b0;
    nreset = 1'b0;
    step();
    step();
    n_cmp++; if (uart_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", uart_wr); end
    n_cmp++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", uart_data); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    nreset = 1'b1;
    step();
    step();
    n_cmp++; if (uart_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr_after: got %b want 0", uart_wr); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int n0;
    int c0;
    n0 = wr_q.size();
    req_data[7:0] = 8'h41;
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL t1_ready: got %b want 01", req_ready); end
    @(posedge clk);
    #2;
    c0 = cyc;
    req_valid = '0;
    n_cmp++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL t1_level1: got %0d want 1", fifo_level); end
    for (int i = 0; i < 20 && wr_q.size() == n0; i++) step();
    n_cmp++; if (wr_q.size() != n0 + 1) begin n_err++; $display("FAIL t1_count: got %0d want %0d", wr_q.size(), n0 + 1); end
    if (wr_q.size() > n0) begin
      n_cmp++; if (wr_q[n0] !== 8'h41) begin n_err++; $display("FAIL t1_byte: got %h want 41", wr_q[n0]); end
      n_cmp++; if (wr_cyc[n0] != c0 + 2) begin n_err++; $display("FAIL t1_latency: got cycle %0d want %0d", wr_cyc[n0], c0 + 2); end
    end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL t1_level0: got %0d want 0", fifo_level); end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int n0;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] exp_g;
    logic [7:0] exp_b [4];
    do_reset();
    exp_b[0] = 8'hA0; exp_b[1] = 8'hB0; exp_b[2] = 8'hA1; exp_b[3] = 8'hB1;
    n0 = wr_q.size();
    a_val = 8'hA0;
    b_val = 8'hB0;
    for (int t = 0; t < 4; t++) begin
      req_data = {b_val, a_val};
      req_valid = 2'b11;
      #1;
      g = req_ready;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL t2_grant%0d: got %b want %b", t, g, exp_g); end
      @(posedge clk);
      #2;
      if (g[0]) a_val = a_val + 8'd1;
      if (g[1]) b_val = b_val + 8'd1;
    end
    req_valid = '0;
    for (int i = 0; i < 200 && wr_q.size() < n0 + 4; i++) step();
    n_cmp++; if (wr_q.size() != n0 + 4) begin n_err++; $display("FAIL t2_count: got %0d want %0d", wr_q.size(), n0 + 4); end
    for (int i = 0; i < 4 && n0 + i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[n0+i] !== exp_b[i]) begin n_err++; $display("FAIL t2_byte%0d: got %h want %h", i, wr_q[n0+i], exp_b[i]); end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_fill();
    int n0;
    logic [7:0] d;
    do_reset();
    force_busy = 1'b1;
    n0 = wr_q.size();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'h10 + 8'(i);
      req_data[7:0] = d;
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL t3_ready%0d: got %b want 01", i, req_ready); end
      @(posedge clk);
      #2;
    end
    req_data[7:0] = 8'h99;
    req_valid = 2'b01;
    #1;
    n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL t3_level: got %0d want 16", fifo_level); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL t3_full_ready: got %b want 00", req_ready); end
    step();
    n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL t3_level_hold: got %0d want 16", fifo_level); end
    req_valid = '0;
    force_busy = 1'b0;
    for (int i = 0; i < 400 && wr_q.size() < n0 + DEPTH; i++) step();
    n_cmp++; if (wr_q.size() != n0 + DEPTH) begin n_err++; $display("FAIL t3_count: got %0d want %0d", wr_q.size(), n0 + DEPTH); end
    for (int i = 0; i < DEPTH && n0 + i < wr_q.size(); i++) begin
      d = 8'h10 + 8'(i);
      n_cmp++; if (wr_q[n0+i] !== d) begin n_err++; $display("FAIL t3_byte%0d: got %h want %h", i, wr_q[n0+i], d); end
    end
    n_cmp++; if (wide_cnt != 0) begin n_err++; $display("FAIL t3_wr_width: got %0d wide strobes want 0", wide_cnt); end
    n_cmp++; if (spacing_err != 0) begin n_err++; $display("FAIL t3_spacing: got %0d close strobes want 0", spacing_err); end
    $display("test_fill done");
  endtask

  task automatic test_reset_mid();
    int n0;
    int n1;
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(0, 8'h60 + 8'(i));
    n0 = wr_q.size();
    force_busy = 1'b0;
    for (int i = 0; i < 20 && wr_q.size() == n0; i++) step();
    force_busy = 1'b1;
    step();
    step();
    n_cmp++; if (fifo_level !== 5'd5) begin n_err++; $display("FAIL t4_level_pre: got %0d want 5", fifo_level); end
    n_cmp++; if (uart_data !== 8'h60) begin n_err++; $display("FAIL t4_data_pre: got %h want 60", uart_data); end
    n1 = wr_q.size();
    nreset = 1'b0;
    #1;
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL t4_level_rst: got %0d want 0", fifo_level); end
    n_cmp++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL t4_data_rst: got %h want 00", uart_data); end
    n_cmp++; if (uart_wr !== 1'b0) begin n_err++; $display("FAIL t4_wr_rst: got %b want 0", uart_wr); end
    nreset = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL t4_ready_rst: got %b want 00", req_ready); end
    force_busy = 1'b0;
    for (int i = 0; i < 30; i++) step();
    n_cmp++; if (wr_q.size() != n1) begin n_err++; $display("FAIL t4_no_wr: got %0d writes want %0d", wr_q.size(), n1); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL t4_level_post: got %0d want 0", fifo_level); end
    $display("test_reset_mid done");
  endtask

  task automatic test_crlf();
    int n0;
    int n_exp;
    logic [7:0] exp_b [4];
`ifdef UART_ARB_CRLF_EN
    exp_b[0] = 8'h48; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A; exp_b[3] = 8'h0D;
    n_exp = 4;
`else
    exp_b[0] = 8'h48; exp_b[1] = 8'h0A; exp_b[2] = 8'h0D; exp_b[3] = 8'h00;
    n_exp = 3;
`endif
    do_reset();
    force_busy = 1'b1;
    push_byte(1, 8'h48);
    push_byte(1, 8'h0A);
    push_byte(0, 8'h0D);
    n0 = wr_q.size();
    force_busy = 1'b0;
    for (int i = 0; i < 200 && wr_q.size() < n0 + n_exp; i++) step();
    for (int i = 0; i < 30; i++) step();
    n_cmp++; if (wr_q.size() != n0 + n_exp) begin n_err++; $display("FAIL t5_count: got %0d want %0d", wr_q.size() - n0, n_exp); end
    for (int i = 0; i < n_exp && n0 + i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[n0+i] !== exp_b[i]) begin n_err++; $display("FAIL t5_byte%0d: got %h want %h", i, wr_q[n0+i], exp_b[i]); end
    end
    $display("test_crlf done");
  endtask

  task automatic test_push_pop();
    int n0;
    logic [7:0] d;
    do_reset();
    force_busy = 1'b1;
    n0 = wr_q.size();
    for (int i = 0; i < 3; i++) push_byte(0, 8'h31 + 8'(i));
    n_cmp++; if (fifo_level !== 5'd3) begin n_err++; $display("FAIL t6_level_pre: got %0d want 3", fifo_level); end
    force_busy = 1'b0;
    step();
    req_data[15:8] = 8'h34;
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL t6_ready: got %b want 10", req_ready); end
    @(posedge clk);
    #2;
    req_valid = '0;
    n_cmp++; if (wr_q.size() != n0 + 1) begin n_err++; $display("FAIL t6_popped: got %0d writes want %0d", wr_q.size() - n0, 1); end
    n_cmp++; if (fifo_level !== 5'd3) begin n_err++; $display("FAIL t6_level_same: got %0d want 3", fifo_level); end
    for (int i = 0; i < 200 && wr_q.size() < n0 + 4; i++) step();
    n_cmp++; if (wr_q.size() != n0 + 4) begin n_err++; $display("FAIL t6_count: got %0d want %0d", wr_q.size() - n0, 4); end
    for (int i = 0; i < 4 && n0 + i < wr_q.size(); i++) begin
      d = 8'h31 + 8'(i);
      n_cmp++; if (wr_q[n0+i] !== d) begin n_err++; $display("FAIL t6_byte%0d: got %h want %h", i, wr_q[n0+i], d); end
    end
    $display("test_push_pop done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fill();
    test_reset_mid();
    test_crlf();
    test_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
